rotary_quad_decoder: RTL and testbench
======================================

# rotary_quad_decoder

Parametrised multi-channel rotary-encoder front end. Each channel synchronises and debounces its raw A/B contacts, derives the hysteretic rotation event (set when both contacts are high, cleared when both are low), resolves direction, and emits a one-cycle step pulse. Each channel also keeps a position counter that either wraps or saturates. It sits between the board's encoder pins and the user-input interface, replacing the single-channel event detector.

## Interface
- NUM_CH, 2, number of independent encoder channels (≥1)
- CNT_W, 8, position counter width per channel (≥2)
- DEB_CYCLES, 4, consecutive stable samples required before a filtered contact value changes (≥1)
- WRAP, 1, 1 = position wraps modulo 2^CNT_W; 0 = position saturates at 0 and 2^CNT_W−1
- clk  in  1  system clock; every register is clocked on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  global step enable; when low, no step pulses and positions hold
- clr  in  NUM_CH  per-channel synchronous clear of position and overflow flag
- rot_a  in  NUM_CH  raw contact A per channel (asynchronous)
- rot_b  in  NUM_CH  raw contact B per channel (asynchronous)
- rot_event  out  NUM_CH  registered hysteretic event level per channel
- step  out  NUM_CH  one-cycle pulse per detected detent
- step_left  out  NUM_CH  direction qualifier, valid while step=1 (1 = left/CCW, 0 = right/CW)
- pos  out  NUM_CH*CNT_W  unsigned position; channel i occupies bits [i*CNT_W +: CNT_W]
- ovf  out  NUM_CH  sticky flag; set on any wrap or saturation attempt

## Operation
- Sync: each raw input passes through 2 flops (s1, s2). Reset value is 0.
- Debounce, per contact:
  - Count consecutive cycles in which s2 differs from the filtered value (fa/fb).
  - Load the filtered value from s2 once s2 has held the new value for DEB_CYCLES samples.
  - Any return to the filtered value resets the count to 0.
  - Reset values: filtered = 0, count = 0.
- Event and direction registers, per channel:
  - fa=1, fb=1 → rot_event<=1.
  - fa=0, fb=0 → rot_event<=0.
  - fa=1, fb=0 → dir<=1.
  - fa=0, fb=1 → dir<=0.
  - Otherwise both registers hold.
- Step: registered pulse step<=en & rot_event & ~rot_event_d, where rot_event_d is rot_event delayed one cycle. In the same edge, step_left<=dir.
- Position update, on the edge where step is asserted:
  - step_left=0 → pos+1.
  - step_left=1 → pos−1.
  - WRAP=1: modular arithmetic. The 2^CNT_W−1→0 and 0→2^CNT_W−1 transitions set ovf.
  - WRAP=0: pos holds at the limit and ovf is set.
- clr[i] has priority over a simultaneous step on channel i: pos<=0, ovf<=0, step pulse still emitted.
- Falling edges of rot_event produce no step. A contact bounce shorter than DEB_CYCLES produces nothing.
- Channels are fully independent. No cross-channel state.
- Reset: all outputs 0 (rot_event, step, step_left, pos, ovf). Assertion mid-operation clears everything immediately, including the debounce counters and dir.

## Timing
- Let edge k be the first edge that samples both raw contacts high, stable from there. Then:
  - Filtered value updates at edge k+1+DEB_CYCLES.
  - rot_event rises at edge k+2+DEB_CYCLES.
  - step, step_left and the new pos are visible after edge k+3+DEB_CYCLES.
- step is high for exactly 1 cycle per rot_event rising edge.
- Minimum detent spacing that resolves correctly is 2·(DEB_CYCLES+1) cycles per contact phase.
- en is sampled on the step-generating edge only. A rot_event rise while en=0 is lost and is not replayed.
- rst_n deassertion has no synchronizer inside this block. The upstream reset bridge guarantees release on a clean clk edge.

## Test plan
- Reset: hold rst_n=0 with rot_a=rot_b=1 → all outputs 0. Release, hold inputs → one step, step_left=0, pos=1 at edge 3+DEB_CYCLES (7 with DEB_CYCLES=4).
- CW then CCW sequences on ch0, ch1 idle:
  - Drive (A,B) 00→10→11→01→00 → step_left=1, pos 0→255, ovf=1 (WRAP=1, CNT_W=8).
  - Then drive 00→01→11→10→00 → step_left=0, pos 255→0.
- Bounce: toggle rot_a for 3 cycles (< DEB_CYCLES=4) while rot_b=1 → rot_event unchanged, no step. Same toggle held 4 cycles → one step.
- Saturation (WRAP=0): 3 CCW detents from pos=0 → pos stays 0, ovf=1 after the first. Assert clr[0] together with the next step → pos=0, ovf=0, step=1.
- Enable and independence: en=0 during a ch1 detent → no step, pos[1] holds. Concurrent detents on ch0 and ch1 in opposite directions → each pos moves ±1 independently.
- Async reset mid-debounce: pulse rst_n low between clk edges, 2 cycles into a stable-high input → all outputs 0 immediately. A full DEB_CYCLES stable window is required afterwards before rot_event rises.

Source files
------------

// File: rtl/rotary_quad_decoder_if.sv
// Bundle of per-channel control, raw encoder contacts and decoded outputs
// for the rotary_quad_decoder front end.
interface rotary_quad_decoder_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
);
    logic                    en;
    logic [NUM_CH-1:0]       clr;
    logic [NUM_CH-1:0]       rot_a;
    logic [NUM_CH-1:0]       rot_b;
    logic [NUM_CH-1:0]       rot_event;
    logic [NUM_CH-1:0]       step;
    logic [NUM_CH-1:0]       step_left;
    logic [NUM_CH*CNT_W-1:0] pos;
    logic [NUM_CH-1:0]       ovf;

    modport master (
        output en, clr, rot_a, rot_b,
        input  rot_event, step, step_left, pos, ovf
    );

    modport slave (
        input  en, clr, rot_a, rot_b,
        output rot_event, step, step_left, pos, ovf
    );
endinterface

// File: rtl/rotary_quad_decoder.sv
// Multi-channel rotary encoder front end: sync, debounce, hysteretic event,
// direction, one-cycle step pulse and a wrapping or saturating position.
module rotary_quad_decoder #(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 8,
    parameter int DEB_CYCLES = 4,
    parameter bit WRAP       = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    rotary_quad_decoder_if.slave bus
);

    localparam int              DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] POS_MAX  = '1;

    // Contact pairs are packed as {a, b}: bit 1 = A, bit 0 = B.
    logic [1:0]       sync1   [NUM_CH];
    logic [1:0]       sync2   [NUM_CH];
    logic [1:0]       filt    [NUM_CH];
    logic [DEB_W-1:0] deb_cnt [NUM_CH][2];
    logic [CNT_W-1:0] pos_q   [NUM_CH];

    logic [NUM_CH-1:0] rot_event_q;
    logic [NUM_CH-1:0] rot_event_d;
    logic [NUM_CH-1:0] dir_q;
    logic [NUM_CH-1:0] step_q;
    logic [NUM_CH-1:0] step_left_q;
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] step_fire;

    assign step_fire = {NUM_CH{bus.en}} & rot_event_q & ~rot_event_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these per-channel arrays are ordinary flops, not RAM, so every element is reset.
            for (int i = 0; i < NUM_CH; i++) begin
                sync1[i]      <= '0;
                sync2[i]      <= '0;
                filt[i]       <= '0;
                deb_cnt[i][0] <= '0;
                deb_cnt[i][1] <= '0;
                pos_q[i]      <= '0;
            end
            rot_event_q <= '0;
            rot_event_d <= '0;
            dir_q       <= '0;
            step_q      <= '0;
            step_left_q <= '0;
            ovf_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rot_event_d <= rot_event_q;
            step_q      <= step_fire;
            step_left_q <= dir_q;
            for (int i = 0; i < NUM_CH; i++) begin
                sync1[i] <= {bus.rot_a[i], bus.rot_b[i]};
                sync2[i] <= sync1[i];

                for (int j = 0; j < 2; j++) begin
                    if (sync2[i][j] == filt[i][j]) begin
                        deb_cnt[i][j] <= '0;
                    end else if (deb_cnt[i][j] == DEB_LAST) begin
                        filt[i][j]    <= sync2[i][j];
                        deb_cnt[i][j] <= '0;
                    end else begin
                        deb_cnt[i][j] <= deb_cnt[i][j] + DEB_W'(1);
                    end
                end

                // Hysteresis: 11 sets the event, 00 clears it, mixed states pick direction.
                case (filt[i])
                    2'b11: rot_event_q[i] <= 1'b1;
                    2'b00: rot_event_q[i] <= 1'b0;
                    2'b10: dir_q[i]       <= 1'b1;
                    2'b01: dir_q[i]       <= 1'b0;
                    default: ;
                endcase

                if (bus.clr[i]) begin
                    pos_q[i] <= '0;
                    ovf_q[i] <= 1'b0;
                end else if (step_fire[i]) begin
                    if (!dir_q[i]) begin
                        if (pos_q[i] == POS_MAX) begin
                            ovf_q[i] <= 1'b1;
                            if (WRAP) pos_q[i] <= '0;
                        end else begin
                            pos_q[i] <= pos_q[i] + CNT_W'(1);
                        end
                    end else begin
                        if (pos_q[i] == '0) begin
                            ovf_q[i] <= 1'b1;
                            if (WRAP) pos_q[i] <= POS_MAX;
                        end else begin
                            pos_q[i] <= pos_q[i] - CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

    assign bus.rot_event = rot_event_q;
    assign bus.step      = step_q;
    assign bus.step_left = step_left_q;
    assign bus.ovf       = ovf_q;

    always_comb begin
        // NOTE: default first so no path through the loop leaves bits unassigned (no latch).
        bus.pos = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.pos[i*CNT_W +: CNT_W] = pos_q[i];
        end
    end

endmodule

// File: tb/tb_rotary_quad_decoder.sv
// Directed bench for rotary_quad_decoder: a wrapping and a saturating instance,
// with expected steps queued at stimulus time and matched by a negedge monitor.
module tb_rotary_quad_decoder;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
    localparam int DEB    = 4;
    localparam int HOLD   = 12;

    typedef struct {
        int         key;
        logic       left;
        logic [7:0] pos;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    rotary_quad_decoder_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bw ();
    rotary_quad_decoder_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bs ();

    rotary_quad_decoder #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEB_CYCLES(DEB), .WRAP(1'b1)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bw)
    );

    rotary_quad_decoder #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEB_CYCLES(DEB), .WRAP(1'b0)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void expect_step(input int d, input int ch, input logic left,
                                        input logic [7:0] p, input logic o);
        exp_t e;
        e.key  = d * 2 + ch;
        e.left = left;
        e.pos  = p;
        e.ovf  = o;
        sb.push_back(e);
    endfunction

    function automatic logic [1:0] phase(input bit ccw, input int k);
        logic [1:0] p;
        case (k)
            0:       p = ccw ? 2'b10 : 2'b01;
            1:       p = 2'b11;
            2:       p = ccw ? 2'b01 : 2'b10;
            default: p = 2'b00;
        endcase
        return p;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ab(input int d, input int ch, input logic [1:0] ab);
        if (d == 1) begin
            bs.rot_a[ch] = ab[1];
            bs.rot_b[ch] = ab[0];
        end else begin
            bw.rot_a[ch] = ab[1];
            bw.rot_b[ch] = ab[0];
        end
    endtask

    task automatic run_seq(input int d, input int ch, input bit ccw);
        for (int k = 0; k < 4; k++) begin
            set_ab(d, ch, phase(ccw, k));
            wait_cyc(HOLD);
        end
    endtask

    // Edge 0 is the first rising edge that samples ch0 of dut_wrap high.
    task automatic latency_check(input string tag);
        for (int e = 0; e <= 8; e++) begin
            @(negedge clk);
            if (e == 5) check({tag, "_event_e5"}, bw.rot_event[0], 0);
            if (e == 6) begin
                check({tag, "_event_e6"}, bw.rot_event[0], 1);
                check({tag, "_step_e6"}, bw.step[0], 0);
            end
            if (e == 7) check({tag, "_step_e7"}, bw.step[0], 1);
            if (e == 8) check({tag, "_step_e8"}, bw.step[0], 0);
        end
    endtask

    // Scoreboard monitor: every observed step must match the oldest queued expectation.
    logic       mon_st;
    logic       mon_left;
    logic [7:0] mon_pos;
    logic       mon_ovf;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    mon_st   = (d == 1) ? bs.step[ch]      : bw.step[ch];
                    mon_left = (d == 1) ? bs.step_left[ch] : bw.step_left[ch];
                    mon_pos  = (d == 1) ? bs.pos[ch*CNT_W +: CNT_W] : bw.pos[ch*CNT_W +: CNT_W];
                    mon_ovf  = (d == 1) ? bs.ovf[ch]       : bw.ovf[ch];
                    if (mon_st) begin
                        check("step_expected", sb.size() != 0, 1);
                        if (sb.size() != 0) begin
                            mon_e = sb.pop_front();
                            check("step_source", d * 2 + ch, mon_e.key);
                            check("step_left", mon_left, mon_e.left);
                            check("step_pos", mon_pos, mon_e.pos);
                            check("step_ovf", mon_ovf, mon_e.ovf);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        bw.en    = 1'b1;
        bw.clr   = '0;
        bw.rot_a = 2'b01;
        bw.rot_b = 2'b01;
        bs.en    = 1'b1;
        bs.clr   = '0;
        bs.rot_a = '0;
        bs.rot_b = '0;

        // Reset held with ch0 contacts high: nothing may move.
        wait_cyc(4);
        check("rst_event", bw.rot_event, 0);
        check("rst_step", bw.step, 0);
        check("rst_left", bw.step_left, 0);
        check("rst_pos", bw.pos, 0);
        check("rst_ovf", bw.ovf, 0);
        check("rst_sat_pos", bs.pos, 0);

        expect_step(0, 0, 1'b0, 8'd1, 1'b0);
        rst_n = 1'b1;
        latency_check("boot");

        // Return ch0 to 00 without a step, then clear to 0.
        set_ab(0, 0, 2'b01);
        wait_cyc(HOLD);
        set_ab(0, 0, 2'b00);
        wait_cyc(HOLD);
        bw.clr[0] = 1'b1;
        wait_cyc(1);
        bw.clr[0] = 1'b0;
        wait_cyc(1);
        check("clr_pos", bw.pos[7:0], 0);

        // CCW detent wraps 0 -> 255, then CW wraps 255 -> 0.
        expect_step(0, 0, 1'b1, 8'd255, 1'b1);
        run_seq(0, 0, 1'b1);
        check("ccw_pos", bw.pos[7:0], 255);
        check("ccw_ovf", bw.ovf[0], 1);
        expect_step(0, 0, 1'b0, 8'd0, 1'b1);
        run_seq(0, 0, 1'b0);
        check("cw_pos", bw.pos[7:0], 0);

        // Bounce on A with B high: 3 samples ignored, 4 samples accepted.
        set_ab(0, 0, 2'b01);
        wait_cyc(HOLD);
        set_ab(0, 0, 2'b11);
        wait_cyc(3);
        set_ab(0, 0, 2'b01);
        wait_cyc(HOLD);
        check("bounce3_event", bw.rot_event[0], 0);
        expect_step(0, 0, 1'b0, 8'd1, 1'b1);
        set_ab(0, 0, 2'b11);
        wait_cyc(DEB);
        set_ab(0, 0, 2'b01);
        wait_cyc(HOLD);
        check("bounce4_event", bw.rot_event[0], 1);
        set_ab(0, 0, 2'b00);
        wait_cyc(HOLD);
        check("bounce_release", bw.rot_event[0], 0);

        // ch1 detent with en low across the rise; en returns while the event is still high.
        bw.en = 1'b0;
        set_ab(0, 1, 2'b01);
        wait_cyc(HOLD);
        set_ab(0, 1, 2'b11);
        wait_cyc(HOLD);
        check("en_event", bw.rot_event[1], 1);
        bw.en = 1'b1;
        set_ab(0, 1, 2'b10);
        wait_cyc(HOLD);
        set_ab(0, 1, 2'b00);
        wait_cyc(HOLD);
        check("en_pos_hold", bw.pos[15:8], 0);

        // Concurrent detents in opposite directions.
        expect_step(0, 0, 1'b0, 8'd2, 1'b1);
        expect_step(0, 1, 1'b1, 8'd255, 1'b1);
        for (int k = 0; k < 4; k++) begin
            set_ab(0, 0, phase(1'b0, k));
            set_ab(0, 1, phase(1'b1, k));
            wait_cyc(HOLD);
        end
        check("conc_pos0", bw.pos[7:0], 2);
        check("conc_pos1", bw.pos[15:8], 255);

        // Saturating instance: three CCW detents from 0.
        for (int n = 0; n < 3; n++) begin
            expect_step(1, 0, 1'b1, 8'd0, 1'b1);
            run_seq(1, 0, 1'b1);
        end
        check("sat_pos", bs.pos[7:0], 0);
        check("sat_ovf", bs.ovf[0], 1);

        // clr held across a CW step edge: clear wins, pulse still emitted.
        set_ab(1, 0, 2'b01);
        wait_cyc(HOLD);
        expect_step(1, 0, 1'b0, 8'd0, 1'b0);
        bs.clr[0] = 1'b1;
        set_ab(1, 0, 2'b11);
        wait_cyc(HOLD);
        bs.clr[0] = 1'b0;
        set_ab(1, 0, 2'b10);
        wait_cyc(HOLD);
        set_ab(1, 0, 2'b00);
        wait_cyc(HOLD);
        check("clr_sat_ovf", bs.ovf[0], 0);
        expect_step(1, 0, 1'b0, 8'd1, 1'b0);
        run_seq(1, 0, 1'b0);
        check("sat_up_pos", bs.pos[7:0], 1);

        // Async reset pulse between edges, two cycles into a stable-high input.
        set_ab(0, 0, 2'b11);
        wait_cyc(2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pos", bw.pos, 0);
        check("arst_ovf", bw.ovf, 0);
        check("arst_event", bw.rot_event, 0);
        check("arst_sat_pos", bs.pos, 0);
        expect_step(0, 0, 1'b0, 8'd1, 1'b0);
        #1 rst_n = 1'b1;
        latency_check("arst");

        wait_cyc(20);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
